// File: rtl/correlator_peak_select.sv
// Frame-level peak selector behind the correlator sum stream.
// Tracks the largest qualifying sum per frame and reports it over valid/ready.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   enable_i          accept sums when high
//   threshold_i       unsigned qualification threshold
//   sum_i, sumid_i    correlator sum and its ID
//   sum_valid_i       strobe for sum_i/sumid_i
//   frame_end_i       strobe closing the current frame
//   trig_valid_o      candidate available (registered)
//   trig_ready_i      downstream accepts candidate
//   peak_o, peakid_o  peak sum and its ID for the reported frame
//   hitcnt_o          qualifying sums in the reported frame
//   drop_cnt_o        saturating count of candidates lost to a busy output
module correlator_peak_select #(
  parameter int SUM_WIDTH  = 27,
  parameter int ID_WIDTH   = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [SUM_WIDTH-1:0]  threshold_i,
  input  logic [SUM_WIDTH-1:0]  sum_i,
  input  logic [ID_WIDTH-1:0]   sumid_i,
  input  logic                  sum_valid_i,
  input  logic                  frame_end_i,
  output logic                  trig_valid_o,
  input  logic                  trig_ready_i,
  output logic [SUM_WIDTH-1:0]  peak_o,
  output logic [ID_WIDTH-1:0]   peakid_o,
  output logic [CNT_WIDTH-1:0]  hitcnt_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q;
  logic [SUM_WIDTH-1:0]  acc_peak_q;
  logic [ID_WIDTH-1:0]   acc_id_q;
  logic [CNT_WIDTH-1:0]  acc_cnt_q;
  logic                  acc_hit_q;
  logic [SUM_WIDTH-1:0]  out_peak_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [CNT_WIDTH-1:0]  out_cnt_q;
  logic [DROP_WIDTH-1:0] drop_q;

  logic                  qual;
  logic                  take_new;
  logic [SUM_WIDTH-1:0]  eff_peak;
  logic [ID_WIDTH-1:0]   eff_id;
  logic [CNT_WIDTH-1:0]  eff_cnt;
  logic                  eff_hit;
  logic                  out_free;
  logic                  load;
  logic                  drop;
  logic                  accept;

  // Effective accumulator: registered state merged with this cycle's sum,
  // so a sum coincident with frame_end_i lands in the closing frame.
  always_comb begin
    qual     = sum_valid_i & enable_i & (sum_i >= threshold_i);
    take_new = qual & (~acc_hit_q | (sum_i > acc_peak_q));
    eff_peak = take_new ? sum_i : acc_peak_q;
    eff_id   = take_new ? sumid_i : acc_id_q;
    eff_cnt  = acc_cnt_q;
    if (qual && acc_cnt_q != '1) begin
      eff_cnt = acc_cnt_q + CNT_WIDTH'(1);
    end
    eff_hit  = acc_hit_q | qual;
    accept   = (state_q == FULL) & trig_ready_i;
    out_free = (state_q == EMPTY) | trig_ready_i;
    load     = frame_end_i & eff_hit & out_free;
    drop     = frame_end_i & eff_hit & ~out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_peak_q <= '0;
      acc_id_q   <= '0;
      acc_cnt_q  <= '0;
      acc_hit_q  <= 1'b0;
    end else if (frame_end_i) begin
      acc_peak_q <= '0;
      acc_id_q   <= '0;
      acc_cnt_q  <= '0;
      acc_hit_q  <= 1'b0;
    end else begin
      acc_peak_q <= eff_peak;
      acc_id_q   <= eff_id;
      acc_cnt_q  <= eff_cnt;
      acc_hit_q  <= eff_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && drop_q != '1) begin
      drop_q <= drop_q + DROP_WIDTH'(1);
    end
  end

  // Output FSM; data registers only change on load so they stay
  // stable for the whole time the candidate is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_peak_q <= '0;
      out_id_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (load) begin
        out_peak_q <= eff_peak;
        out_id_q   <= eff_id;
        out_cnt_q  <= eff_cnt;
      end
      unique case (state_q)
        EMPTY: if (load) state_q <= FULL;
        FULL:  if (accept && !load) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign trig_valid_o = (state_q == FULL);
  assign peak_o       = out_peak_q;
  assign peakid_o     = out_id_q;
  assign hitcnt_o     = out_cnt_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_correlator_peak_select.sv
// Directed bench for correlator_peak_select.
// Hand-computed expectations; one checking task.
module tb_correlator_peak_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [26:0] threshold_i;
  logic [26:0] sum_i;
  logic [7:0]  sumid_i;
  logic        sum_valid_i;
  logic        frame_end_i;
  logic        trig_valid_o;
  logic        trig_ready_i;
  logic [26:0] peak_o;
  logic [7:0]  peakid_o;
  logic [7:0]  hitcnt_o;
  logic [15:0] drop_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  correlator_peak_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .threshold_i  (threshold_i),
    .sum_i        (sum_i),
    .sumid_i      (sumid_i),
    .sum_valid_i  (sum_valid_i),
    .frame_end_i  (frame_end_i),
    .trig_valid_o (trig_valid_o),
    .trig_ready_i (trig_ready_i),
    .peak_o       (peak_o),
    .peakid_o     (peakid_o),
    .hitcnt_o     (hitcnt_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_sum(input int s, input int id);
    sum_i       = 27'(s);
    sumid_i     = 8'(id);
    sum_valid_i = 1'b1;
    step();
    sum_valid_i = 1'b0;
  endtask

  task automatic fend();
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
  endtask

  task automatic take();
    trig_ready_i = 1'b1;
    step();
    trig_ready_i = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    enable_i     = 1'b1;
    threshold_i  = 27'd100;
    sum_i        = '0;
    sumid_i      = '0;
    sum_valid_i  = 1'b0;
    frame_end_i  = 1'b0;
    trig_ready_i = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(trig_valid_o), 0);
    chk("rst_peak", 32'(peak_o), 0);
    chk("rst_id", 32'(peakid_o), 0);
    chk("rst_hit", 32'(hitcnt_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    rst_n = 1'b1;
    step();

    // basic peak
    put_sum(50, 8'h00);
    put_sum(300, 8'hFF);
    put_sum(200, 8'h00);
    chk("pre_valid", 32'(trig_valid_o), 0);
    fend();
    chk("t1_valid", 32'(trig_valid_o), 1);
    chk("t1_peak", 32'(peak_o), 300);
    chk("t1_id", 32'(peakid_o), 32'hFF);
    chk("t1_hit", 32'(hitcnt_o), 2);
    take();
    chk("t1_acc", 32'(trig_valid_o), 0);

    // tie plus sum coincident with frame_end
    threshold_i = 27'd0;
    put_sum(40, 8'h01);
    sum_i       = 27'd40;
    sumid_i     = 8'h02;
    sum_valid_i = 1'b1;
    frame_end_i = 1'b1;
    step();
    sum_valid_i = 1'b0;
    frame_end_i = 1'b0;
    chk("t2_valid", 32'(trig_valid_o), 1);
    chk("t2_peak", 32'(peak_o), 40);
    chk("t2_id", 32'(peakid_o), 1);
    chk("t2_hit", 32'(hitcnt_o), 2);
    take();

    // empty frame
    threshold_i = 27'd1000;
    put_sum(999, 8'h03);
    put_sum(5, 8'h04);
    fend();
    chk("t3_valid", 32'(trig_valid_o), 0);
    chk("t3_drop", 32'(drop_cnt_o), 0);

    // backpressure
    threshold_i = 27'd100;
    put_sum(500, 8'h05);
    fend();
    put_sum(600, 8'h06);
    fend();
    chk("t4_valid", 32'(trig_valid_o), 1);
    chk("t4_peak", 32'(peak_o), 500);
    chk("t4_id", 32'(peakid_o), 5);
    chk("t4_drop", 32'(drop_cnt_o), 1);
    take();
    chk("t4_acc", 32'(trig_valid_o), 0);
    put_sum(700, 8'h07);
    fend();
    chk("t4b_valid", 32'(trig_valid_o), 1);
    chk("t4b_peak", 32'(peak_o), 700);
    chk("t4b_drop", 32'(drop_cnt_o), 1);
    take();

    // accept and load in the same cycle
    put_sum(500, 8'h08);
    fend();
    put_sum(800, 8'h09);
    frame_end_i  = 1'b1;
    trig_ready_i = 1'b1;
    step();
    frame_end_i  = 1'b0;
    trig_ready_i = 1'b0;
    chk("t5_valid", 32'(trig_valid_o), 1);
    chk("t5_peak", 32'(peak_o), 800);
    chk("t5_id", 32'(peakid_o), 9);
    chk("t5_drop", 32'(drop_cnt_o), 1);
    take();
    chk("t5_acc", 32'(trig_valid_o), 0);

    // reset mid-frame
    put_sum(900, 8'h0A);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    chk("t6_rdrop", 32'(drop_cnt_o), 0);
    fend();
    chk("t6_valid", 32'(trig_valid_o), 0);

    // enable low blocks accumulation
    enable_i = 1'b0;
    put_sum(900, 8'h0B);
    fend();
    chk("t7_valid", 32'(trig_valid_o), 0);
    enable_i = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
